// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-requester register-file write arbiter.
package arbitro_pkg;

    localparam int ANCHO_DATO_DEF   = 32;
    localparam int ANCHO_DIR_DEF    = 5;
    localparam int ANCHO_CONFLICTOS = 16;

    typedef enum logic {
        ULTIMO_0 = 1'b0,
        ULTIMO_1 = 1'b1
    } ultimo_t;

endpackage

// File: rtl/arbitro_rr2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// a conflict goes to the requester that was not granted last.
module arbitro_rr2
    import arbitro_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  logic    bloqueo,
    input  ultimo_t ultimo,
    output logic    grant0,
    output logic    grant1
);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!bloqueo) begin
            grant0 = valid0 && (!valid1 || ultimo == ULTIMO_1);
            grant1 = valid1 && (!valid0 || ultimo == ULTIMO_0);
        end
    end

endmodule

// File: rtl/arbitro_escritura.sv
// Register-file write arbiter: picks one of two writeback sources per cycle
// and presents the winning write one cycle later.
module arbitro_escritura
    import arbitro_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req0_valid,
    input  logic [ANCHO_DIR-1:0]        req0_dir,
    input  logic [ANCHO_DATO-1:0]       req0_dato,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [ANCHO_DIR-1:0]        req1_dir,
    input  logic [ANCHO_DATO-1:0]       req1_dato,
    output logic                        req1_ready,
    input  logic                        bloqueo,
    output logic                        regEscribir,
    output logic [ANCHO_DIR-1:0]        C,
    output logic [ANCHO_DATO-1:0]       WE,
    output logic                        concesion,
    output logic [ANCHO_CONFLICTOS-1:0] conflictos
);

    ultimo_t ultimo;
    ultimo_t ultimo_next;
    logic    grant0;
    logic    grant1;
    logic    transfer;
    logic [ANCHO_DIR-1:0]  sel_dir;
    logic [ANCHO_DATO-1:0] sel_dato;

    arbitro_rr2 u_rr2 (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .bloqueo (bloqueo),
        .ultimo  (ultimo),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    // Reset also masks the readies so nothing is accepted on a reset edge.
    assign req0_ready = grant0 && !rst;
    assign req1_ready = grant1 && !rst;
    assign transfer   = req0_ready || req1_ready;
    assign sel_dir    = req1_ready ? req1_dir  : req0_dir;
    assign sel_dato   = req1_ready ? req1_dato : req0_dato;

    always_ff @(posedge clk) begin
        if (rst) begin
            ultimo <= ULTIMO_1;
        end else begin
            ultimo <= ultimo_next;
        end
    end

    always_comb begin
        ultimo_next = ultimo;
        if (req0_ready) begin
            ultimo_next = ULTIMO_0;
        end else if (req1_ready) begin
            ultimo_next = ULTIMO_1;
        end
    end

    // Writes to register zero are accepted but never pulse the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            regEscribir <= 1'b0;
            C           <= '0;
            WE          <= '0;
            concesion   <= 1'b0;
        end else begin
            regEscribir <= transfer && (sel_dir != '0);
            if (transfer) begin
                C         <= sel_dir;
                WE        <= sel_dato;
                concesion <= req1_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflictos <= '0;
        end else if (req0_valid && req1_valid && !bloqueo && conflictos != '1) begin
            conflictos <= conflictos + 1'b1;
        end
    end

endmodule
